// File: rtl/fifo_frame_ctrl.sv
// fifo_frame_ctrl
//   Front-end controller for the byte-in / frame-out asynchronous FIFO.
//   Two byte requesters share the FIFO write port through round-robin
//   arbitration. The controller tracks how many bytes sit in the FIFO, and
//   once a whole frame has accumulated it pulses the FIFO read strobe. It
//   then presents the frame downstream with a valid/ready handshake.
//
// Ports
//   clk          : single clock, shared with the FIFO
//   rst          : asynchronous active-high reset (also resets the FIFO)
//   req0_valid   : requester 0 has a byte
//   req0_data    : requester 0 byte
//   req0_ready   : requester 0 byte accepted this cycle (combinational)
//   req1_valid   : requester 1 has a byte
//   req1_data    : requester 1 byte
//   req1_ready   : requester 1 byte accepted this cycle (combinational)
//   fifo_wdata   : FIFO write data, registered, held between writes
//   fifo_winc    : FIFO write strobe, one cycle per byte
//   fifo_rinc    : FIFO read strobe, one cycle per frame
//   frame_valid  : FIFO data_out holds a complete frame
//   frame_ready  : consumer takes the frame (ignored outside PRESENT)
//   level        : bytes accepted and not yet popped
//   frames_out   : frames handed off, wraps 255 -> 0
//
// FSM
//   state   | meaning
//   IDLE    | waiting for level >= FRAME_BYTES
//   POP     | one cycle, fifo_rinc high, frame bytes debited from level
//   PRESENT | frame_valid high until frame_ready

module fifo_frame_ctrl #(
  parameter int DW          = 8,
  parameter int FRAME_BYTES = 15,
  parameter int DEPTH       = 16,
  parameter int LW          = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] fifo_wdata,
  output logic          fifo_winc,
  output logic          fifo_rinc,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [LW-1:0] level,
  output logic [7:0]    frames_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_POP     = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] FRAME_L = LW'(FRAME_BYTES);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          last_grant;
  logic          full;
  logic          gnt0;
  logic          gnt1;
  logic          accept;
  logic [DW-1:0] gnt_data;
  logic          enter_pop;
  logic          frame_done;
  logic [LW-1:0] level_inc;
  logic [LW-1:0] level_next;

  assign full = (level == DEPTH_L);

  // Round-robin: on contention the requester that did not win last time gets
  // the port. last_grant resets to 1 so req0 wins the first contention.
  // Gating with rst keeps the ready outputs low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !full) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign gnt_data   = gnt1 ? req1_data : req0_data;

  assign enter_pop  = (state == S_IDLE) && (level >= FRAME_L);
  assign frame_done = (state == S_PRESENT) && frame_ready;

  // A byte accepted on the same edge as the pop debit nets +1-FRAME_BYTES.
  // A pop needs level >= FRAME_BYTES, so the subtraction cannot underflow.
  assign level_inc  = level + LW'(accept);
  assign level_next = level_inc - (enter_pop ? FRAME_L : '0);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (enter_pop) state_next = S_POP;
      S_POP:     state_next = S_PRESENT;
      S_PRESENT: if (frame_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      level      <= '0;
      frames_out <= '0;
      fifo_wdata <= '0;
      fifo_winc  <= 1'b0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      fifo_winc <= accept;
      if (accept) begin
        fifo_wdata <= gnt_data;
        last_grant <= gnt1;
      end
      if (frame_done) frames_out <= frames_out + 8'd1;
    end
  end

  // Decoded straight from state so both drop the moment reset hits.
  assign fifo_rinc   = (state == S_POP);
  assign frame_valid = (state == S_PRESENT);

endmodule

// File: tb/tb_fifo_frame_ctrl.sv
module tb_fifo_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] fifo_wdata;
  logic       fifo_winc;
  logic       fifo_rinc;
  logic       frame_valid;
  logic       frame_ready;
  logic [4:0] level;
  logic [7:0] frames_out;

  int n_cmp;
  int n_bad;

  fifo_frame_ctrl #(.DW(8), .FRAME_BYTES(15), .DEPTH(16), .LW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .fifo_wdata  (fifo_wdata),
    .fifo_winc   (fifo_winc),
    .fifo_rinc   (fifo_rinc),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .level       (level),
    .frames_out  (frames_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    frame_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h55;
    req1_data = 8'h66;
    frame_ready = 1'b1;
    #3;
    step();
    n_cmp++;
    if (fifo_winc !== 1'b0 || fifo_rinc !== 1'b0 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: winc=%b rinc=%b fvalid=%b required 0 0 0", fifo_winc, fifo_rinc, frame_valid);
    end
    n_cmp++;
    if (fifo_wdata !== 8'h00 || level !== 5'd0 || frames_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_values: wdata=%h level=%0d frames=%0d required 0 0 0", fifo_wdata, level, frames_out);
    end
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: r0=%b r1=%b required 0 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    frame_ready = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    do_reset();
    frame_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      req0_valid = 1'b1;
      req0_data = 8'(i);
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL single_ready[%0d]: r0=%b r1=%b required 1 0", i, req0_ready, req1_ready);
      end
      step();
      n_cmp++;
      if (fifo_winc !== 1'b1 || fifo_wdata !== 8'(i) || level !== 5'(i)) begin
        n_bad++;
        $display("FAIL single_write[%0d]: winc=%b wdata=%h level=%0d required 1 %h %0d", i, fifo_winc, fifo_wdata, level, 8'(i), i);
      end
    end
    req0_valid = 1'b0;
    step();
    n_cmp++;
    if (fifo_rinc !== 1'b1 || level !== 5'd0 || frame_valid !== 1'b0 || fifo_winc !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pop: rinc=%b level=%0d fvalid=%b winc=%b required 1 0 0 0", fifo_rinc, level, frame_valid, fifo_winc);
    end
    step();
    n_cmp++;
    if (fifo_rinc !== 1'b0 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_present: rinc=%b fvalid=%b required 0 1", fifo_rinc, frame_valid);
    end
    step();
    n_cmp++;
    if (frame_valid !== 1'b0 || frames_out !== 8'd1 || level !== 5'd0) begin
      n_bad++;
      $display("FAIL single_done: fvalid=%b frames=%0d level=%0d required 0 1 0", frame_valid, frames_out, level);
    end
  endtask

  task automatic test_arbitration();
    int a;
    int b;
    logic exp_g0;
    logic [7:0] exp_d;
    do_reset();
    frame_ready = 1'b1;
    a = 0;
    b = 0;
    for (int k = 0; k < 10; k++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data = 8'hA0 + 8'(a);
      req1_data = 8'hB0 + 8'(b);
      exp_g0 = ((k % 2) == 0);
      exp_d = exp_g0 ? 8'hA0 + 8'(a) : 8'hB0 + 8'(b);
      #1;
      n_cmp++;
      if (req0_ready !== exp_g0 || req1_ready !== !exp_g0) begin
        n_bad++;
        $display("FAIL arb_grant[%0d]: r0=%b r1=%b required %b %b", k, req0_ready, req1_ready, exp_g0, !exp_g0);
      end
      step();
      n_cmp++;
      if (fifo_winc !== 1'b1 || fifo_wdata !== exp_d) begin
        n_bad++;
        $display("FAIL arb_data[%0d]: winc=%b wdata=%h required 1 %h", k, fifo_winc, fifo_wdata, exp_d);
      end
      if (exp_g0) a++;
      else b++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    n_cmp++;
    if (level !== 5'd10 || fifo_winc !== 1'b0) begin
      n_bad++;
      $display("FAIL arb_level: level=%0d winc=%b required 10 0", level, fifo_winc);
    end
  endtask

  task automatic test_backpressure();
    int exp_lvl;
    do_reset();
    frame_ready = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      req1_valid = 1'b1;
      req1_data = 8'h10 + 8'(k);
      exp_lvl = (k <= 15) ? k : k - 15;
      #1;
      n_cmp++;
      if (req1_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: r1=%b required 1", k, req1_ready);
      end
      step();
      n_cmp++;
      if (fifo_winc !== 1'b1 || fifo_wdata !== 8'h10 + 8'(k) || level !== 5'(exp_lvl)) begin
        n_bad++;
        $display("FAIL bp_write[%0d]: winc=%b wdata=%h level=%0d required 1 %h %0d", k, fifo_winc, fifo_wdata, level, 8'h10 + 8'(k), exp_lvl);
      end
      n_cmp++;
      if (fifo_rinc !== (k == 16) || frame_valid !== (k >= 17)) begin
        n_bad++;
        $display("FAIL bp_fsm[%0d]: rinc=%b fvalid=%b required %b %b", k, fifo_rinc, frame_valid, (k == 16), (k >= 17));
      end
      if (k == 16) begin
        n_cmp++;
        if (level !== 5'd1) begin
          n_bad++;
          $display("FAIL pop_and_accept: level=%0d required 1", level);
        end
      end
    end
    req0_valid = 1'b1;
    req0_data = 8'h98;
    req1_data = 8'h99;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full_ready: r0=%b r1=%b required 0 0", req0_ready, req1_ready);
    end
    step();
    n_cmp++;
    if (fifo_winc !== 1'b0 || level !== 5'd16 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_full_hold: winc=%b level=%0d fvalid=%b required 0 16 1", fifo_winc, level, frame_valid);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    frame_ready = 1'b1;
    step();
    n_cmp++;
    if (frame_valid !== 1'b0 || frames_out !== 8'd1 || level !== 5'd16 || fifo_rinc !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: fvalid=%b frames=%0d level=%0d rinc=%b required 0 1 16 0", frame_valid, frames_out, level, fifo_rinc);
    end
    step();
    n_cmp++;
    if (fifo_rinc !== 1'b1 || level !== 5'd1) begin
      n_bad++;
      $display("FAIL bp_second_pop: rinc=%b level=%0d required 1 1", fifo_rinc, level);
    end
    step();
    n_cmp++;
    if (frame_valid !== 1'b1 || fifo_rinc !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_second_present: fvalid=%b rinc=%b required 1 0", frame_valid, fifo_rinc);
    end
    step();
    step();
    n_cmp++;
    if (frames_out !== 8'd2 || frame_valid !== 1'b0 || level !== 5'd1) begin
      n_bad++;
      $display("FAIL bp_idle_ignore: frames=%0d fvalid=%b level=%0d required 2 0 1", frames_out, frame_valid, level);
    end
  endtask

  task automatic test_reset_in_present();
    int rinc_cnt;
    do_reset();
    frame_ready = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      req0_valid = 1'b1;
      req0_data = 8'h40 + 8'(k);
      step();
    end
    req0_valid = 1'b0;
    n_cmp++;
    if (level !== 5'd7 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rip_setup: level=%0d fvalid=%b required 7 1", level, frame_valid);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (frame_valid !== 1'b0 || level !== 5'd0 || fifo_wdata !== 8'h00 || frames_out !== 8'd0) begin
      n_bad++;
      $display("FAIL rip_async: fvalid=%b level=%0d wdata=%h frames=%0d required 0 0 00 0", frame_valid, level, fifo_wdata, frames_out);
    end
    n_cmp++;
    if (fifo_winc !== 1'b0 || fifo_rinc !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rip_strobes: winc=%b rinc=%b r0=%b r1=%b required 0 0 0 0", fifo_winc, fifo_rinc, req0_ready, req1_ready);
    end
    step();
    step();
    n_cmp++;
    if (fifo_winc !== 1'b0 || fifo_rinc !== 1'b0 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rip_held: winc=%b rinc=%b fvalid=%b required 0 0 0", fifo_winc, fifo_rinc, frame_valid);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    frame_ready = 1'b1;
    step();
    n_cmp++;
    if (fifo_winc !== 1'b0 || fifo_rinc !== 1'b0) begin
      n_bad++;
      $display("FAIL rip_post_release: winc=%b rinc=%b required 0 0", fifo_winc, fifo_rinc);
    end
    rinc_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      req0_valid = 1'b1;
      req0_data = 8'(k);
      step();
      if (fifo_rinc === 1'b1) rinc_cnt++;
    end
    req0_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (fifo_rinc === 1'b1) rinc_cnt++;
    end
    n_cmp++;
    if (rinc_cnt != 1 || frames_out !== 8'd1 || level !== 5'd0) begin
      n_bad++;
      $display("FAIL rip_refill: pops=%0d frames=%0d level=%0d required 1 1 0", rinc_cnt, frames_out, level);
    end
  endtask

  task automatic test_frames_wrap();
    int hs;
    int cyc;
    do_reset();
    frame_ready = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h5A;
    hs = 0;
    cyc = 0;
    while (hs < 256 && cyc < 6000) begin
      step();
      cyc++;
      if (frame_valid === 1'b1) hs++;
    end
    n_cmp++;
    if (hs != 256) begin
      n_bad++;
      $display("FAIL wrap_timeout: frames seen=%0d required 256", hs);
    end
    n_cmp++;
    if (frames_out !== 8'd255) begin
      n_bad++;
      $display("FAIL wrap_255: frames=%0d required 255", frames_out);
    end
    req0_valid = 1'b0;
    step();
    n_cmp++;
    if (frames_out !== 8'd0 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_zero: frames=%0d fvalid=%b required 0 0", frames_out, frame_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    frame_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_arbitration();
    test_backpressure();
    test_reset_in_present();
    test_frames_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
